// File: rtl/intc_priority_ctrl_pkg.sv
// Shared types and constants for the fixed-priority interrupt controller.
// Holds the FSM state encoding and the lowest-index priority encoder.
package intc_pkg;

  localparam int MAX_SRC = 4;
  localparam int VEC_W   = 2;
  localparam logic [MAX_SRC-1:0] MASK_RST = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Index of the lowest set bit; index 0 wins, so scan from the top down.
  function automatic logic [VEC_W-1:0] prio_enc(input logic [MAX_SRC-1:0] v);
    prio_enc = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = VEC_W'(i);
    end
  endfunction

endpackage

// File: rtl/intc_priority_ctrl_if.sv
// CPU-side bus of the interrupt controller: mask write, request/vector,
// ack/eoi handshake and the status snapshot.
interface intc_priority_ctrl_if #(
  parameter int N_SRC = 3
);
  import intc_pkg::*;

  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             irq_ack;
  logic             irq_eoi;
  logic             irq_req;
  logic [VEC_W-1:0] irq_vector;
  logic [7:0]       status;

  modport master (
    output mask_we, mask_wdata, irq_ack, irq_eoi,
    input  irq_req, irq_vector, status
  );

  modport slave (
    input  mask_we, mask_wdata, irq_ack, irq_eoi,
    output irq_req, irq_vector, status
  );

endinterface

// File: rtl/intc_priority_ctrl_edge_sync.sv
// Two-flop synchroniser for one raw interrupt line, followed by a rising-edge
// detector that emits a single-cycle pulse on the synchronised level.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pulse = sync & ~sync_d;

endmodule

// File: rtl/intc_priority_ctrl.sv
// Fixed-priority interrupt controller: pending/mask/in-service registers,
// lowest-index selection and the req/ack/eoi sequencer.
// Define INTC_NEST_EN to let a higher-priority source pre-empt a service.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | nothing in service, no request outstanding
// ST_REQ     | irq_req high, irq_vector frozen until ack or mask-out
// ST_SERVICE | at least one source in service, no request outstanding
module intc_priority_ctrl
  import intc_pkg::*;
#(
  parameter int N_SRC = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     irq_in,
  intc_priority_ctrl_if.slave  bus
);

  state_t           state;
  logic             irq_req;
  logic [VEC_W-1:0] irq_vector;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] in_service;
  logic [N_SRC-1:0] mask;

  logic [N_SRC-1:0] edge_pulse;
  logic [N_SRC-1:0] vec_oh;
  logic [N_SRC-1:0] lowest_ins;
  logic [N_SRC-1:0] allow;
  logic [N_SRC-1:0] sel;
  logic [N_SRC-1:0] ins_next;
  logic [N_SRC-1:0] pend_next;
  logic [N_SRC-1:0] mask_next;
  logic [VEC_W-1:0] sel_vec;
  logic             sel_any;
  logic             ack_fire;
  logic             vec_masked;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_edge_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (irq_in[g]),
      .pulse    (edge_pulse[g])
    );
  end

  always_comb begin
    vec_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      vec_oh[i] = (irq_vector == VEC_W'(i));
    end
  end

  assign ack_fire   = (state == ST_REQ) && bus.irq_ack;
  assign lowest_ins = in_service & (~in_service + N_SRC'(1));

`ifdef INTC_NEST_EN
  // Only sources strictly above the most urgent in-service one may pre-empt.
  assign allow = (in_service == '0) ? '1 : (lowest_ins - N_SRC'(1));
`else
  assign allow = (in_service == '0) ? '1 : '0;
`endif

  assign sel        = pending & ~mask & allow;
  assign sel_any    = |sel;
  assign sel_vec    = prio_enc(MAX_SRC'(sel));
  assign vec_masked = |(mask & vec_oh);

  // A fresh edge on the acked source re-sets pending: set wins over clear.
  assign ins_next  = (in_service & ~(bus.irq_eoi ? lowest_ins : '0))
                   | (ack_fire ? vec_oh : '0);
  assign pend_next = (pending & ~(ack_fire ? vec_oh : '0)) | edge_pulse;
  assign mask_next = bus.mask_we ? bus.mask_wdata : mask;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      irq_req    <= 1'b0;
      irq_vector <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= MASK_RST[N_SRC-1:0];
    end else begin
      pending    <= pend_next;
      in_service <= ins_next;
      mask       <= mask_next;
      case (state)
        ST_IDLE: begin
          if (sel_any) begin
            state      <= ST_REQ;
            irq_req    <= 1'b1;
            irq_vector <= sel_vec;
          end
        end
        ST_REQ: begin
          if (ack_fire) begin
            state   <= ST_SERVICE;
            irq_req <= 1'b0;
          end else if (vec_masked) begin
            state   <= (ins_next == '0) ? ST_IDLE : ST_SERVICE;
            irq_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (ins_next == '0) begin
            state <= ST_IDLE;
          end else if (!bus.irq_eoi && sel_any) begin
            state      <= ST_REQ;
            irq_req    <= 1'b1;
            irq_vector <= sel_vec;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_req    = irq_req;
  assign bus.irq_vector = irq_vector;
  assign bus.status     = {MAX_SRC'(in_service), MAX_SRC'(pending)};

endmodule

// File: tb/tb_intc_priority_ctrl.sv
// Bench for intc_priority_ctrl: directed scenarios plus random traffic,
// every cycle compared against a rule-level reference model.
module tb_intc_priority_ctrl;
  import intc_pkg::*;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_in;

  intc_priority_ctrl_if #(.N_SRC(N)) bus ();

  intc_priority_ctrl #(.N_SRC(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  int m_pend, m_ins, m_mask, m_vec;
  bit m_req;
  int samp [3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_idx(input int v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return N;
  endfunction

  // One clock edge of the controller expressed as its stated rules.
  task automatic model_step();
    int edges, o_pend, o_ins, o_mask, cand, lim, pick;
    bit ack;
    if (!reset) begin
      m_pend = 0; m_ins = 0; m_mask = (1 << N) - 1; m_req = 0; m_vec = 0;
      samp[0] = 0; samp[1] = 0; samp[2] = 0;
      return;
    end
    // edge seen at this clock = line high two samples ago, low three ago
    edges   = samp[1] & ~samp[2];
    samp[2] = samp[1];
    samp[1] = samp[0];
    samp[0] = int'(irq_in);
    o_pend = m_pend; o_ins = m_ins; o_mask = m_mask;
    ack = m_req && bus.irq_ack;

    m_ins = o_ins;
    if (bus.irq_eoi && o_ins != 0) m_ins = o_ins & ~(1 << lowest_idx(o_ins));
    if (ack) m_ins = m_ins | (1 << m_vec);
    m_pend = o_pend;
    if (ack) m_pend = m_pend & ~(1 << m_vec);
    m_pend = m_pend | edges;
    if (bus.mask_we) m_mask = int'(bus.mask_wdata);

    if (m_req) begin
      if (ack || o_mask[m_vec]) m_req = 0;
    end else if (!(bus.irq_eoi && o_ins != 0)) begin
      cand = o_pend & ~o_mask;
`ifdef INTC_NEST_EN
      lim = (o_ins == 0) ? N : lowest_idx(o_ins);
`else
      lim = (o_ins == 0) ? N : 0;
`endif
      pick = lowest_idx(cand);
      if (pick < lim) begin
        m_req = 1;
        m_vec = pick;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_val("req", 32'(bus.irq_req), 32'(m_req));
    check_val("vec", 32'(bus.irq_vector), 32'(m_vec));
    check_val("status", 32'(bus.status), 32'({m_ins[3:0], m_pend[3:0]}));
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1; cycle(); bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.irq_eoi = 1'b1; cycle(); bus.irq_eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    bus.mask_we = 1'b1; bus.mask_wdata = m; cycle(); bus.mask_we = 1'b0;
  endtask

  // drive a one-sample pulse on the given lines, then idle three cycles
  task automatic raise(input logic [N-1:0] v);
    irq_in = v; cycle(); irq_in = '0;
    cycle(); cycle(); cycle();
  endtask

  initial begin
    reset = 1'b0; irq_in = '0;
    bus.mask_we = 1'b0; bus.mask_wdata = '0; bus.irq_ack = 1'b0; bus.irq_eoi = 1'b0;

    cycle(); cycle();
    check_val("rst_req", 32'(bus.irq_req), 32'd0);
    check_val("rst_vec", 32'(bus.irq_vector), 32'd0);
    check_val("rst_status", 32'(bus.status), 32'h00);
    reset = 1'b1;
    cycle();

    // four-cycle latency from sampled edge to request
    write_mask(3'b000);
    irq_in = 3'b100; cycle(); irq_in = '0;
    cycle(); cycle();
    check_val("lat_early_req", 32'(bus.irq_req), 32'd0);
    check_val("lat_pending", 32'(bus.status), 32'h04);
    cycle();
    check_val("lat_req", 32'(bus.irq_req), 32'd1);
    check_val("lat_vec", 32'(bus.irq_vector), 32'd2);
    pulse_ack();
    check_val("ack_status", 32'(bus.status), 32'h40);
    pulse_eoi();
    check_val("eoi_status", 32'(bus.status), 32'h00);

    // simultaneous sources: lower index first
    raise(3'b110);
    check_val("prio_vec", 32'(bus.irq_vector), 32'd1);
    pulse_ack();
    check_val("prio_status", 32'(bus.status), 32'h24);
    pulse_eoi();
    check_val("prio_gap", 32'(bus.irq_req), 32'd0);
    cycle();
    check_val("prio_next_req", 32'(bus.irq_req), 32'd1);
    check_val("prio_next_vec", 32'(bus.irq_vector), 32'd2);
    pulse_ack(); pulse_eoi();

    // masked source latches pending but stays quiet until unmasked
    write_mask(3'b001);
    irq_in = 3'b001; cycle(); irq_in = '0;
    cycle(); cycle();
    check_val("masked_pend", 32'(bus.status), 32'h01);
    cycle();
    check_val("masked_req", 32'(bus.irq_req), 32'd0);
    write_mask(3'b000);
    check_val("unmask_wait", 32'(bus.irq_req), 32'd0);
    cycle();
    check_val("unmask_req", 32'(bus.irq_req), 32'd1);
    check_val("unmask_vec", 32'(bus.irq_vector), 32'd0);
    pulse_ack(); pulse_eoi();

    // masking the requested source withdraws the request, pending kept
    raise(3'b100);
    check_val("mreq_vec", 32'(bus.irq_vector), 32'd2);
    write_mask(3'b100);
    check_val("mdrop_hold", 32'(bus.irq_req), 32'd1);
    cycle();
    check_val("mdrop_req", 32'(bus.irq_req), 32'd0);
    check_val("mdrop_pend", 32'(bus.status), 32'h04);
    write_mask(3'b000);
    cycle();
    check_val("mdrop_rereq", 32'(bus.irq_req), 32'd1);
    pulse_ack(); pulse_eoi();

    // higher-priority arrival while servicing source 2
    raise(3'b100);
    pulse_ack();
    check_val("nest_svc", 32'(bus.status), 32'h40);
    raise(3'b001);
`ifdef INTC_NEST_EN
    check_val("nest_req", 32'(bus.irq_req), 32'd1);
    check_val("nest_vec", 32'(bus.irq_vector), 32'd0);
    pulse_ack();
    check_val("nest_ins", 32'(bus.status), 32'h50);
    pulse_eoi();
    check_val("nest_eoi1", 32'(bus.status), 32'h40);
    pulse_eoi();
`else
    check_val("nonest_req", 32'(bus.irq_req), 32'd0);
    check_val("nonest_pend", 32'(bus.status), 32'h41);
    pulse_eoi();
    cycle();
    check_val("nonest_after", 32'(bus.irq_vector), 32'd0);
    pulse_ack(); pulse_eoi();
`endif
    check_val("nest_done", 32'(bus.status), 32'h00);

    // new edge on source 1 coincides with its ack: pending survives
    irq_in = 3'b010; cycle(); irq_in = '0;
    cycle(); cycle();
    irq_in = 3'b010; cycle(); irq_in = '0;
    check_val("race_req", 32'(bus.irq_vector), 32'd1);
    cycle();
    pulse_ack();
    check_val("race_status", 32'(bus.status), 32'h22);
    pulse_eoi();
    cycle();
    check_val("race_rereq", 32'(bus.irq_req), 32'd1);
    pulse_ack(); pulse_eoi();

    // reset in the middle of a request
    raise(3'b100);
    reset = 1'b0; cycle();
    check_val("rst_mid_req", 32'(bus.irq_req), 32'd0);
    check_val("rst_mid_status", 32'(bus.status), 32'h00);
    reset = 1'b1;
    cycle();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
      bus.irq_ack    = ($urandom_range(3) == 0);
      bus.irq_eoi    = ($urandom_range(5) == 0);
      bus.mask_we    = ($urandom_range(15) == 0);
      bus.mask_wdata = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      reset          = ($urandom_range(499) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/intc_priority_ctrl.md
# intc_priority_ctrl

Fixed-priority interrupt controller between the raw interrupt lines (timer output plus the two external lines) and the CPU interrupt input. Synchronises and edge-detects each source, latches pending requests, applies a CPU-written mask, and presents one request and vector at a time to the CPU. Sequencing uses a req/ack/end-of-interrupt handshake. Source 0 (timer) has the highest priority.

## Interface
- N_SRC, 3: number of interrupt sources, legal range 1..4; index 0 has the highest priority.
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- irq_in  in  N_SRC  raw level sources (bit 0 = timer, bits 2:1 = external lines); asynchronous to clk.
- mask_we  in  1  writes mask_wdata into the mask register.
- mask_wdata  in  N_SRC  1 = source masked.
- irq_ack  in  1  CPU accepts the current request.
- irq_eoi  in  1  CPU finished servicing; one-cycle pulse.
- irq_req  out  1  interrupt request to the CPU.
- irq_vector  out  2  index of the requested source.
- status  out  8  {in_service zero-extended to 4 bits, pending zero-extended to 4 bits}.

## Operation
- Per source: 2-flop synchroniser, then rising-edge detect on the synchronised level. An edge sets pending[i].
- Masked sources still latch pending but never request.
- Selection: lowest-index bit of (pending & ~mask), subject to the nesting rule below.
- States:
  - IDLE: no in_service bit set and no request.
  - REQ: irq_req=1.
  - SERVICE: at least one in_service bit set, no request outstanding.
- Transitions:
  - IDLE -> REQ when the selection is non-empty. irq_vector is loaded and irq_req is set.
  - REQ -> SERVICE on irq_ack. Clears pending[vector] and sets in_service[vector].
  - REQ -> IDLE (or SERVICE if in_service ≠ 0) when the selected source becomes masked. irq_req drops.
  - SERVICE -> IDLE on irq_eoi once in_service becomes 0.
- irq_vector is frozen while irq_req=1. A higher-priority arrival waits for ack.
- irq_eoi clears the lowest-index set in_service bit. irq_eoi in IDLE/REQ with in_service=0 is ignored.
- irq_ack while irq_req=0 is ignored.
- Simultaneous new edge on source i and ack clearing pending[i]: set wins, and pending[i] stays 1.
- Simultaneous mask_we and ack: the ack is honoured. The new mask applies from the next cycle.
- Reset values: irq_req 0, irq_vector 0, status 0, pending 0, in_service 0, mask all ones (all masked), synchroniser flops 0, state IDLE.
- Reset asserted mid-handshake aborts everything to the reset values. No request survives.

## Timing
- irq_in rising sampled at edge k: sync at k, k+1; pending set at k+2; irq_req=1 after k+3 (4-cycle latency, unmasked, IDLE).
- irq_ack sampled with irq_req=1 at edge t: irq_req=0 after t, and in_service visible in status after t.
- Back-to-back: if another source is pending, irq_req re-asserts no earlier than one cycle after the ack edge (and only if allowed by nesting rule/EOI).
- mask_we at edge t: mask effective for selection after t; irq_req drop, if any, after t+1.
- A source held high produces one pending event only; it must go low for ≥2 cycles to re-trigger.

## Configuration
- INTC_NEST_EN defined: in SERVICE, a source with index below the lowest set in_service bit may raise a new request (REQ with in_service ≠ 0). The ack adds to in_service and nesting depth ≤ N_SRC.
- INTC_NEST_EN undefined: no request while any in_service bit is set. Selection resumes only after the EOI that empties in_service.

## Structure
- Package intc_pkg: state enum (ST_IDLE, ST_REQ, ST_SERVICE), MAX_SRC=4, VEC_W=2, MASK_RST (all ones).
- Sub-module irq_edge_sync: one instance per source, containing the 2-flop synchroniser and the rising-edge pulse output.
- Top: pending/mask/in_service registers, priority encoder, FSM.

## Test plan
- Reset low 2 cycles -> all outputs 0, status=8'h00. Write mask=3'b000; pulse irq_in[2] -> irq_req=1, vector=2, 4 cycles after the edge.
- irq_in=3'b110 same cycle, mask 0 -> vector=1 first. Ack -> status=8'h24. EOI -> then vector=2.
- Mask=3'b001, raise irq_in[0] -> pending bit set (status=8'h01), irq_req stays 0. Unmask -> irq_req=1, vector=0.
- While REQ vector=2, write mask=3'b100 -> irq_req=0 next cycle, state IDLE, pending[2] retained.
- In SERVICE for source 2, raise irq_in[0] -> irq_req=1, vector=0 with INTC_NEST_EN. Without it irq_req=0 until EOI.
- Edge on irq_in[1] in the same cycle as ack of source 1 -> pending[1]=1 after ack. Assert reset during REQ -> irq_req=0 next edge.
